// File: rtl/usb_tx_scheduler_if.sv
// Handshake bundle between the protocol engine / usb_tx and the TX scheduler.
// The master side issues requests and tx_done; the slave side is the scheduler.
interface usb_tx_scheduler_if;
  logic       ack_req;
  logic       nak_req;
  logic       data_req;
  logic [6:0] buffer_occupancy;
  logic       tx_done;
  logic       clear_err;
  logic [2:0] tx_packet;
  logic       tx_busy;
  logic       pkt_sent;
  logic       timeout_err;

  modport master (
    output ack_req, nak_req, data_req, buffer_occupancy, tx_done, clear_err,
    input  tx_packet, tx_busy, pkt_sent, timeout_err
  );

  modport slave (
    input  ack_req, nak_req, data_req, buffer_occupancy, tx_done, clear_err,
    output tx_packet, tx_busy, pkt_sent, timeout_err
  );
endinterface

// File: rtl/usb_tx_scheduler.sv
// USB transmit sequencer: latches ACK/NAK/DATA requests, issues one command at a time,
// waits for EOP (or watchdog expiry) and holds an inter-packet gap before the next.
module usb_tx_scheduler #(
  parameter int TIMEOUT_CYCLES = 6000,
  parameter int GAP_CYCLES     = 16,
  parameter int CNT_W          = 13
) (
  input  logic              clk,
  input  logic              rst,
  usb_tx_scheduler_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, GAP} state_t;

  localparam logic [2:0]       PKT_IDLE = 3'd0;
  localparam logic [2:0]       PKT_DATA = 3'd1;
  localparam logic [2:0]       PKT_ACK  = 3'd2;
  localparam logic [2:0]       PKT_NAK  = 3'd3;
  localparam logic [CNT_W-1:0] WD_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);

  state_t           state;
  logic [2:0]       pend;        // {nak, ack, data}
  logic [CNT_W-1:0] cnt;         // watchdog in WAIT, gap timer in GAP
  logic [2:0]       tx_packet_r;
  logic             tx_busy_r;
  logic             timeout_err_r;

  logic [2:0] req;
  logic [2:0] eff;
  logic [2:0] sel;
  logic [2:0] sel_code;
  logic [2:0] consumed;
  logic [2:0] pend_nxt;
  logic       issue;
  logic       done_ok;
  logic       expire;

  // A request arriving in IDLE is served directly so the command appears the next cycle.
  // If that request was not already pending it is consumed by the issue; a request that
  // merely repeats an already-pending type re-arms the bit for another round.
  always_comb begin
    req      = {bus.nak_req, bus.ack_req, bus.data_req};
    eff      = pend | req;
    sel      = 3'b000;
    sel_code = PKT_IDLE;
    if (eff[2]) begin
      sel      = 3'b100;
      sel_code = PKT_NAK;
    end else if (eff[1]) begin
      sel      = 3'b010;
      sel_code = PKT_ACK;
    end else if (eff[0]) begin
      sel      = 3'b001;
      sel_code = (bus.buffer_occupancy == 7'd0) ? PKT_NAK : PKT_DATA;
    end
    issue    = (state == IDLE) && (eff != 3'b000);
    consumed = issue ? (sel & ~pend) : 3'b000;
    pend_nxt = (pend & ~(issue ? sel : 3'b000)) | (req & ~consumed);
  end

  // tx_done wins over a simultaneous watchdog expiry.
  assign done_ok = (state == WAIT) && bus.tx_done;
  assign expire  = (state == WAIT) && !bus.tx_done && (cnt == WD_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      pend          <= 3'b000;
      cnt           <= '0;
      tx_packet_r   <= PKT_IDLE;
      tx_busy_r     <= 1'b0;
      timeout_err_r <= 1'b0;
    end else begin
      pend        <= pend_nxt;
      tx_packet_r <= PKT_IDLE;
      if (expire) begin
        timeout_err_r <= 1'b1;
      end else if (bus.clear_err) begin
        timeout_err_r <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (issue) begin
            state       <= ISSUE;
            tx_packet_r <= sel_code;
            tx_busy_r   <= 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT;
          cnt   <= '0;
        end
        WAIT: begin
          if (done_ok || expire) begin
            state <= GAP;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            state     <= IDLE;
            tx_busy_r <= 1'b0;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx_packet   = tx_packet_r;
  assign bus.tx_busy     = tx_busy_r;
  assign bus.pkt_sent    = done_ok;
  assign bus.timeout_err = timeout_err_r;

endmodule

// File: tb/tb_usb_tx_scheduler.sv
// Bench for usb_tx_scheduler: directed scenarios plus random traffic, all checked every
// cycle against a timestamp-based reference model of the scheduler.
module tb_usb_tx_scheduler;
  localparam int TIMEOUT_CYCLES = 6000;
  localparam int GAP_CYCLES     = 16;
  localparam int CNT_W          = 13;
  localparam int INF            = 1 << 30;

  logic tb_clk = 1'b0;
  logic rst    = 1'b0;
  always #5 tb_clk = ~tb_clk;

  usb_tx_scheduler_if bus();

  usb_tx_scheduler #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .GAP_CYCLES    (GAP_CYCLES),
    .CNT_W         (CNT_W)
  ) dut (
    .clk(tb_clk),
    .rst(rst),
    .bus(bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: pending flags plus timestamps of the packet in flight.
  bit m_pend[3];          // 0 DATA, 1 ACK, 2 NAK
  int m_issue = -1;       // cycle in which the command is on tx_packet
  int m_end   = -1;       // cycle of accepted tx_done or watchdog expiry
  int m_idle  = -1;       // first IDLE cycle after the gap
  int m_code  = 0;
  bit m_err   = 0;
  bit model_valid = 0;
  int seen[$];            // nonzero commands observed on tx_packet

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) m_pend[i] = 0;
    m_issue = -1;
    m_end   = -1;
    m_idle  = -1;
    m_code  = 0;
    m_err   = 0;
  endtask

  task automatic step(input bit r, input bit a, input bit n, input bit d,
                      input int occ, input bit done, input bit clr);
    bit active, waiting, set_err, any;
    bit req[3];
    int s;
    @(negedge tb_clk);
    rst                  = r;
    bus.ack_req          = a;
    bus.nak_req          = n;
    bus.data_req         = d;
    bus.buffer_occupancy = 7'(occ);
    bus.tx_done          = done;
    bus.clear_err        = clr;
    #1;
    active  = (m_issue >= 0) && (cyc < m_idle);
    waiting = active && (cyc > m_issue) && (m_end < 0);
    if (bus.tx_packet !== 3'd0) seen.push_back(int'(bus.tx_packet));
    if (model_valid) begin
      check("tx_packet",   bus.tx_packet,   (cyc == m_issue) ? m_code : 0);
      check("tx_busy",     bus.tx_busy,     active);
      check("pkt_sent",    bus.pkt_sent,    waiting && done);
      check("timeout_err", bus.timeout_err, m_err);
    end
    if (r) begin
      model_reset();
      model_valid = 1;
    end else begin
      set_err = 0;
      req[0] = d; req[1] = a; req[2] = n;
      if (waiting) begin
        if (done) begin
          m_end  = cyc;
          m_idle = cyc + GAP_CYCLES + 1;
        end else if (cyc - m_issue - 1 == TIMEOUT_CYCLES - 1) begin
          m_end   = cyc;
          m_idle  = cyc + GAP_CYCLES + 1;
          set_err = 1;
        end
      end
      any = 0;
      s   = -1;
      if (!active) begin
        if (m_pend[2] || req[2])      s = 2;
        else if (m_pend[1] || req[1]) s = 1;
        else if (m_pend[0] || req[0]) s = 0;
        any = (s >= 0);
      end
      if (any) begin
        m_code  = (s == 2) ? 3 : (s == 1) ? 2 : ((occ == 0) ? 3 : 1);
        m_issue = cyc + 1;
        m_end   = -1;
        m_idle  = INF;
        // a fresh request that gets issued is used up; an already-pending one is re-armed
        if (m_pend[s]) begin
          m_pend[s] = req[s];
        end else begin
          req[s] = 0;
        end
      end
      for (int i = 0; i < 3; i++) m_pend[i] = m_pend[i] | req[i];
      if (set_err)  m_err = 1;
      else if (clr) m_err = 0;
    end
    cyc++;
  endtask

  task automatic idle(input int n, input int occ);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, occ, 0, 0);
  endtask

  // Answer each issued command with tx_done dly cycles later.
  task automatic respond(input int n, input int occ, input int dly);
    for (int i = 0; i < n; i++)
      step(0, 0, 0, 0, occ, (m_issue >= 0) && (cyc == m_issue + dly), 0);
  endtask

  initial begin
    bus.ack_req = 0; bus.nak_req = 0; bus.data_req = 0;
    bus.buffer_occupancy = '0; bus.tx_done = 0; bus.clear_err = 0;

    // reset held two cycles, then quiet
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    idle(20, 0);

    // single ACK, answered late
    step(0, 1, 0, 0, 0, 0, 0);
    respond(230, 0, 189);
    check("ack_seen", seen.size(), 1);
    if (seen.size() > 0) check("ack_code", seen[0], 2);

    // simultaneous requests with a full FIFO: NAK, ACK, DATA in turn
    seen.delete();
    step(0, 1, 1, 1, 64, 0, 0);
    respond(150, 64, 25);
    check("prio_count", seen.size(), 3);
    if (seen.size() == 3) begin
      check("prio_0", seen[0], 3);
      check("prio_1", seen[1], 2);
      check("prio_2", seen[2], 1);
    end

    // DATA with an empty FIFO goes out as NAK and is not retried
    seen.delete();
    step(0, 0, 0, 1, 0, 0, 0);
    respond(100, 0, 10);
    check("empty_count", seen.size(), 1);
    if (seen.size() > 0) check("empty_code", seen[0], 3);

    // watchdog expiry, sticky error, clear, then normal service
    step(0, 0, 0, 1, 10, 0, 0);
    idle(TIMEOUT_CYCLES + 20, 10);
    check("timeout_set", bus.timeout_err, 1);
    check("timeout_idle", bus.tx_busy, 0);
    step(0, 0, 0, 0, 10, 0, 1);
    idle(1, 10);
    check("timeout_clr", bus.timeout_err, 0);
    seen.delete();
    step(0, 1, 0, 0, 10, 0, 0);
    respond(60, 10, 12);
    check("after_clr", seen.size(), 1);

    // reset while waiting with a NAK pending
    step(0, 1, 0, 0, 10, 0, 0);
    idle(3, 10);
    step(0, 0, 1, 0, 10, 0, 0);
    step(1, 0, 0, 0, 10, 0, 0);
    seen.delete();
    idle(40, 10);
    check("rst_drop", seen.size(), 0);

    // random traffic, including stray tx_done, clears and occasional resets
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(499) == 0),
           ($urandom_range(15) == 0), ($urandom_range(15) == 0), ($urandom_range(9) == 0),
           ($urandom_range(3) == 0) ? 0 : int'($urandom_range(64)),
           ($urandom_range(24) == 0), ($urandom_range(63) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
